clk_div: RTL and testbench

//  Ripple divide-by-2 clock chain feeding the deserializer tree clocks (desclk[STAGES:1]).

---
 rtl/clk_div.sv | 107 ++++++++++
 tb/tb_clk_div.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/clk_div.sv
// Ripple divide-by-2 clock chain: clkout[k] = clkin / 2^(k+1), 50% duty, all taps phase-aligned.
// Latency: clkout[0] first rises on the 1st clkin rising edge after rstb rises (3rd with CLKDIV_RST_SYNC_EN).
// Backpressure: none; free-running clock generator, rstb is the only control.
//
// Ports:
//   clkin  - fast input clock, root of the chain
//   rstb   - asynchronous active-low reset; forces every latch and every tap to 0
//   clkout - divided clocks, bit k = clkin / 2^(k+1)
//
// Build option: define CLKDIV_RST_SYNC_EN to pass rstb deassertion through a
// 2-flop synchronizer on clkin (assertion stays asynchronous).
//
// Each stage is a master neg_latch + slave pos_latch with inverted feedback.
// The latches have no reset pin: reset gates the latch data/output with the
// internal reset and forces both latch enables open, so the stored state is
// cleared immediately regardless of the stage clock level.

module neg_latch (
    input  logic clkb,
    input  logic d,
    output logic q
);
    // Transparent while clkb is low.
    always_latch begin
        if (!clkb) q <= d;
    end
endmodule

module pos_latch (
    input  logic clk,
    input  logic d,
    output logic q
);
    // Transparent while clk is high.
    always_latch begin
        if (clk) q <= d;
    end
endmodule

module clk_div #(
    parameter int STAGES = 2
) (
    input  logic              clkin,
    input  logic              rstb,
    output logic [STAGES-1:0] clkout
);

    logic rst_n_int;

`ifdef CLKDIV_RST_SYNC_EN
    logic [1:0] rst_sync;

    // Deassertion is retimed to clkin; assertion clears the flops at once.
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n_int = rst_sync[1];
`else
    assign rst_n_int = rstb;
`endif

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        logic stg_clk;
        logic m_q;
        logic s_q;
        logic m_d;
        logic s_d;
        logic m_clkb;
        logic s_clk;

        if (k == 0) begin : g_src_root
            assign stg_clk = clkin;
        end else begin : g_src_tap
            assign stg_clk = clkout[k-1];
        end

        // During reset both latches are held transparent with a 0 data input,
        // so master and slave state clear without waiting for a clock level.
        // Out of reset these reduce to the plain stage clock.
        assign m_clkb = stg_clk & rst_n_int;
        assign s_clk  = stg_clk | ~rst_n_int;

        // Inverted feedback: master samples the complement of the tap while the
        // stage clock is low, slave presents it on the rising edge.
        assign m_d = ~s_q & rst_n_int;
        assign s_d = m_q & rst_n_int;

        neg_latch u_master (
            .clkb (m_clkb),
            .d    (m_d),
            .q    (m_q)
        );

        pos_latch u_slave (
            .clk  (s_clk),
            .d    (s_d),
            .q    (s_q)
        );

        // Output gating makes a high tap drop the instant reset asserts.
        assign clkout[k] = s_q & rst_n_int;
    end

endmodule

// File: tb/tb_clk_div.sv
`timescale 1ns/1ps
module tb_clk_div;

    logic       clkin;
    logic       rstb;
    logic [0:0] c1;
    logic [1:0] c2;
    logic [2:0] c3;

    clk_div #(.STAGES(1)) dut1 (.clkin(clkin), .rstb(rstb), .clkout(c1));
    clk_div #(.STAGES(2)) dut2 (.clkin(clkin), .rstb(rstb), .clkout(c2));
    clk_div #(.STAGES(3)) dut3 (.clkin(clkin), .rstb(rstb), .clkout(c3));

`ifdef CLKDIV_RST_SYNC_EN
    localparam int FIRST = 3;
`else
    localparam int FIRST = 1;
`endif

    typedef struct {
        logic       rstb_in;
        logic [2:0] exp3;
    } vec_t;

    vec_t tbl[$];

    // {c2,c1,c0} after the k-th clkin rise counted from the first tap rise.
    logic [2:0] pat [8] = '{3'b111, 3'b110, 3'b101, 3'b100,
                            3'b011, 3'b010, 3'b001, 3'b000};

    int checks = 0;
    int errors = 0;

    initial begin
        clkin = 1'b0;
        forever #0.5 clkin = ~clkin;
    end

    // Rising-edge counters on the 3-stage taps.
    int rise0 = 0;
    int rise1 = 0;
    int rise2 = 0;
    always @(posedge c3[0]) rise0 <= rise0 + 1;
    always @(posedge c3[1]) rise1 <= rise1 + 1;
    always @(posedge c3[2]) rise2 <= rise2 + 1;

    // 1:4 deserializer: bits shift in on clkin, a word is taken once per
    // clkout[1] period (detected at the clkin falling edge after its rise).
    logic [3:0] words [16];
    logic [3:0] cap   [32];
    logic [3:0] sr = 4'h0;
    logic [3:0] wtmp;
    logic       din = 1'b0;
    logic       cur_bit;
    logic       des_en = 1'b0;
    logic       c1_prev = 1'b0;
    int         pe = 0;
    int         ncap = 0;
    int         din_idx;

    always @(posedge clkin or negedge rstb) begin
        if (!rstb) pe <= 0;
        else       pe <= pe + 1;
    end

    assign din_idx = pe - FIRST;

    always_comb begin
        cur_bit = 1'b0;
        wtmp    = 4'h0;
        if (des_en && din_idx >= 0 && din_idx < 64) begin
            wtmp    = words[din_idx[5:2]];
            cur_bit = wtmp[~din_idx[1:0]];
        end
    end

    always @(posedge clkin) sr <= {sr[2:0], din};

    always @(negedge clkin) begin
        din     <= cur_bit;
        c1_prev <= c2[1];
        if (!des_en) begin
            ncap <= 0;
        end else if (c2[1] && !c1_prev && ncap < 32) begin
            cap[ncap[4:0]] <= sr;
            ncap           <= ncap + 1;
        end
    end

    task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic run_table(input int start, input string tag);
        for (int i = start; i < tbl.size(); i++) begin
            rstb = tbl[i].rstb_in;
            @(posedge clkin);
            #0.25;
            chk($sformatf("%s%0d_s3", tag, i), c3, tbl[i].exp3);
            chk($sformatf("%s%0d_s2", tag, i), {1'b0, c2}, {1'b0, tbl[i].exp3[1:0]});
            chk($sformatf("%s%0d_s1", tag, i), {2'b00, c1}, {2'b00, tbl[i].exp3[0]});
        end
    endtask

    int s0, s1, s2;

    initial begin
        rstb = 1'b0;
        for (int i = 0; i < 16; i++) words[i] = 4'($urandom_range(0, 15));

        // 5 reset cycles, then release: zeros until the first rise, then the pattern.
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 3'b000});
        for (int i = 0; i < FIRST - 1; i++) tbl.push_back('{1'b1, 3'b000});
        for (int i = 0; i < 16; i++) tbl.push_back('{1'b1, pat[i % 8]});

        run_table(0, "tbl");

        // Short reset pulse while taps are high: immediate clear, clean restart.
        @(posedge clkin);
        #0.25;
        chk("pre_pulse_s2", {1'b0, c2}, 3'b011);
        chk("pre_pulse_s3", c3, 3'b111);
        rstb = 1'b0;
        #0.01;
        chk("pulse_s1", {2'b00, c1}, 3'b000);
        chk("pulse_s2", {1'b0, c2}, 3'b000);
        chk("pulse_s3", c3, 3'b000);
        #0.29;
        rstb = 1'b1;
        run_table(5, "rep");

        // Rising-edge counts over 64 clkin cycles from the first tap rise.
        rstb = 1'b0;
        repeat (2) @(posedge clkin);
        #0.25;
        s0 = rise0;
        s1 = rise1;
        s2 = rise2;
        rstb = 1'b1;
        repeat (FIRST + 63) @(posedge clkin);
        #0.25;
        chk_int("rises_c0", rise0 - s0, 32);
        chk_int("rises_c1", rise1 - s1, 16);
        chk_int("rises_c2", rise2 - s2, 8);

        // Deserializer on {clkout, clkin}: 16 random words recovered in order.
        rstb   = 1'b0;
        des_en = 1'b1;
        repeat (2) @(posedge clkin);
        #0.25;
        rstb = 1'b1;
        repeat (FIRST + 65) @(posedge clkin);
        #0.25;
        chk_int("des_count", ncap, 17);
        if (ncap >= 17) begin
            for (int j = 1; j <= 16; j++)
                chk($sformatf("des_word%0d", j - 1), {1'b0, cap[j][3:2]} , {1'b0, words[j-1][3:2]});
            for (int j = 1; j <= 16; j++)
                chk($sformatf("des_word%0d_lo", j - 1), {1'b0, cap[j][1:0]}, {1'b0, words[j-1][1:0]});
        end
        des_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
